root_dispatcher: RTL

ROOT_DISPATCHER -- requirements
Module: root_dispatcher

---
 rtl/root_pkg.sv | 17 +
 rtl/root_req_fifo.sv | 53 +++++
 rtl/root_dispatcher.sv | 114 +++++++++++
 3 files changed

// File: rtl/root_pkg.sv
// Shared widths, queued request record and FSM state encoding for the root dispatcher.
package root_pkg;
    localparam int RAD_W = 10;
    localparam int DEG_W = 3;
    localparam int RES_W = 20;

    typedef struct packed {
        logic [RAD_W-1:0] radicand;
        logic [DEG_W-1:0] degree;
    } req_t;

    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_ISSUE = 2'd1;
    localparam state_t ST_WAIT  = 2'd2;
    localparam state_t ST_HOLD  = 2'd3;
endpackage

// File: rtl/root_req_fifo.sv
// Generic synchronous FIFO of DEPTH entries (power of 2) with wrap-around pointers.
// Latency: a pushed entry is visible at the head one cycle after the push.
// Backpressure: push ignored while full, pop ignored while empty; no pass-through.
module root_req_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    // full is judged on the registered count, so a same-cycle pop never frees a slot
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_data = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/root_dispatcher.sv
// Queues root requests and runs them one at a time through an external root engine.
// Latency: push to eng_in_valid 2 cycles (idle, empty); engine result to rsp_valid 1 cycle.
// Backpressure: req_ready drops while the queue is full; a response is held until rsp_ready.
module root_dispatcher
    import root_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int TIMEOUT = 255
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [RAD_W-1:0] req_radicand,
    input  logic [DEG_W-1:0] req_degree,
    output logic             eng_in_valid,
    output logic [RAD_W-1:0] eng_in_data_1,
    output logic [DEG_W-1:0] eng_in_data_2,
    input  logic             eng_out_valid,
    input  logic [RES_W-1:0] eng_out_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [RES_W-1:0] rsp_data,
    output logic [DEG_W-1:0] rsp_degree,
    output logic             rsp_err,
    output logic             busy
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    state_t           state;
    logic [CNT_W-1:0] wait_cnt;
    req_t             req_in;
    req_t             head;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fifo_pop;
    logic             in_flight;

    assign req_in    = {req_radicand, req_degree};
    assign req_ready = !fifo_full && !rst;
    assign fifo_pop  = (state == ST_HOLD) && rsp_ready;

    root_req_fifo #(
        .WIDTH ($bits(req_t)),
        .DEPTH (DEPTH)
    ) u_req_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_valid && req_ready),
        .push_data (req_in),
        .pop       (fifo_pop),
        .head_data (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The head entry stays put until the response handshake, so it doubles as the engine operand register
    assign in_flight     = (state == ST_ISSUE) || (state == ST_WAIT);
    assign eng_in_valid  = (state == ST_ISSUE);
    assign eng_in_data_1 = in_flight ? head.radicand : '0;
    assign eng_in_data_2 = in_flight ? head.degree   : '0;
    assign rsp_valid     = (state == ST_HOLD);
    assign busy          = (state != ST_IDLE) || !fifo_empty;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= '0;
            rsp_data   <= '0;
            rsp_degree <= '0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        if (head.degree == '0) begin
                            state      <= ST_HOLD;
                            rsp_data   <= '0;
                            rsp_degree <= head.degree;
                            rsp_err    <= 1'b1;
                        end else begin
                            state <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: begin
                    state    <= ST_WAIT;
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    // A result landing on the timeout cycle still counts as a result
                    if (eng_out_valid) begin
                        state      <= ST_HOLD;
                        rsp_data   <= eng_out_data;
                        rsp_degree <= head.degree;
                        rsp_err    <= 1'b0;
                    end else if (wait_cnt == CNT_LAST) begin
                        state      <= ST_HOLD;
                        rsp_data   <= '0;
                        rsp_degree <= head.degree;
                        rsp_err    <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (rsp_ready) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
